// File: rtl/usr_ctrl_pkg.sv
// Shared constants for the universal-shift-register transmit sequencer:
// register mode encodings and the controller state encoding.
package usr_ctrl_pkg;

  localparam logic [1:0] USR_MODE_HOLD = 2'b00;
  localparam logic [1:0] USR_MODE_SHR  = 2'b01;
  localparam logic [1:0] USR_MODE_SHL  = 2'b10;
  localparam logic [1:0] USR_MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_PARITY = 2'b11
  } usr_state_e;

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register driven by the transmit sequencer: hold, shift right,
// shift left or parallel load, gated by enable.
module universal_shift_register
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (enable) begin
      case (mode)
        USR_MODE_SHR:  q <= {serial_in_right, q[WIDTH-1:1]};
        USR_MODE_SHL:  q <= {q[WIDTH-2:0], serial_in_left};
        USR_MODE_LOAD: q <= parallel_in;
        default:       q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_bit_timer.sv
// Bit-period timer: DIV_W down-counter reloaded with div on start or at terminal
// count; tick marks the last cycle of each div+1 cycle period.
module usr_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start || tick) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/usr_serial_tx_ctrl.sv
// Parallel-to-serial transmit sequencer around an external universal shift register.
// Optional even-parity bit appended per frame when USR_CTRL_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | ready for a word; capture data and config on accept
// LOAD   | parallel-load captured word into the register
// SHIFT  | present one bit per period, shift at each period end
// PARITY | extra bit period carrying even parity, register held
module usr_serial_tx_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_msb_first,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             sr_enable,
  output logic [1:0]       sr_mode,
  output logic             sr_serial_in_right,
  output logic             sr_serial_in_left,
  output logic [WIDTH-1:0] sr_parallel_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  usr_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             msb_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             tick;
  logic             timer_start;
  logic             accept;
  logic             unused_sr_q;
`ifdef USR_CTRL_PARITY_EN
  logic             par_q;
`endif

  assign sr_serial_in_right = 1'b0;
  assign sr_serial_in_left  = 1'b0;
  assign accept             = in_valid && in_ready;
  // Only the end bits of q are observed; the middle is consumed by shifting.
  assign unused_sr_q        = ^sr_q;

  usr_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .div   (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      msb_q     <= 1'b0;
      div_q     <= '0;
      bit_cnt_q <= '0;
`ifdef USR_CTRL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        msb_q  <= cfg_msb_first;
        div_q  <= cfg_div;
`ifdef USR_CTRL_PARITY_EN
        par_q  <= ^in_data;
`endif
      end
      if (state_q == ST_LOAD) begin
        bit_cnt_q <= '0;
      end else if (state_q == ST_SHIFT && tick) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    sr_enable      = 1'b0;
    sr_mode        = USR_MODE_HOLD;
    sr_parallel_in = '0;
    ser_out        = 1'b0;
    ser_valid      = 1'b0;
    frame_done     = 1'b0;
    timer_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while rst is asserted so nothing is accepted during reset.
        in_ready = !rst;
        if (in_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sr_enable      = 1'b1;
        sr_mode        = USR_MODE_LOAD;
        sr_parallel_in = data_q;
        timer_start    = 1'b1;
        state_d        = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb_q ? sr_q[WIDTH-1] : sr_q[0];
        if (tick) begin
          sr_enable = 1'b1;
          sr_mode   = msb_q ? USR_MODE_SHL : USR_MODE_SHR;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef USR_CTRL_PARITY_EN
            state_d = ST_PARITY;
`else
            frame_done = 1'b1;
            state_d    = ST_IDLE;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef USR_CTRL_PARITY_EN
        ser_valid = 1'b1;
        ser_out   = par_q;
        if (tick) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_serial_tx_ctrl.sv
// Self-checking bench for usr_serial_tx_ctrl driving universal_shift_register (WIDTH=8);
// honours USR_CTRL_PARITY_EN for the parity frame checks.
module tb_usr_serial_tx_ctrl;

  localparam int W  = 8;
  localparam int DW = 8;
`ifdef USR_CTRL_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          cfg_msb_first = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic          in_ready, sr_enable, sr_sir, sr_sil, ser_out, ser_valid, frame_done;
  logic [1:0]    sr_mode;
  logic [W-1:0]  sr_pin, sr_q;

  always #5 clk = ~clk;

  usr_serial_tx_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_msb_first(cfg_msb_first), .cfg_div(cfg_div), .sr_enable(sr_enable),
    .sr_mode(sr_mode), .sr_serial_in_right(sr_sir), .sr_serial_in_left(sr_sil),
    .sr_parallel_in(sr_pin), .sr_q(sr_q), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_done(frame_done)
  );

  universal_shift_register #(.WIDTH(W)) u_sr (
    .clk(clk), .rst(rst), .enable(sr_enable), .mode(sr_mode), .serial_in_right(sr_sir),
    .serial_in_left(sr_sil), .parallel_in(sr_pin), .q(sr_q)
  );

  typedef struct packed {
    logic         busy;
    logic         v;
    logic         o;
    logic         d;
    logic         en;
    logic [1:0]   m;
    logic [W-1:0] pin;
  } rec_t;

  rec_t q_exp[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   last_acc_cyc = -1;
  int   last_done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference serializer: one record per cycle from the LOAD cycle to the end of the frame.
  task automatic push_frame(input logic [W-1:0] d, input logic msb, input int div);
    rec_t r;
    logic b_val;
    r = '0;
    r.busy = 1'b1; r.en = 1'b1; r.m = 2'b11; r.pin = d;
    q_exp.push_back(r);
    for (int b = 0; b < NB; b++) begin
      b_val = (b < W) ? (msb ? d[W-1-b] : d[b]) : ^d;
      for (int k = 0; k <= div; k++) begin
        r = '0;
        r.busy = 1'b1;
        r.v    = 1'b1;
        r.o    = b_val;
        r.d    = (k == div) && (b == NB - 1);
        r.en   = (k == div) && (b < W);
        r.m    = r.en ? (msb ? 2'b10 : 2'b01) : 2'b00;
        q_exp.push_back(r);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    chk_en = 1'b1;
    if (rst) begin
      q_exp.delete();
    end else if (in_valid && in_ready) begin
      push_frame(in_data, cfg_msb_first, int'(cfg_div));
      last_acc_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (chk_en) begin
      if (q_exp.size() > 0) e = q_exp.pop_front();
      else e = '0;
      chk("in_ready", in_ready, !e.busy && !rst);
      chk("ser_valid", ser_valid, e.v);
      if (e.v) chk("ser_out", ser_out, e.o);
      chk("frame_done", frame_done, e.d);
      chk("sr_enable", sr_enable, e.en);
      chk("sr_mode", sr_mode, e.m);
      chk("sr_parallel_in", sr_pin, e.pin);
      chk("sr_serial_in", {sr_sir, sr_sil}, 2'b00);
      if (frame_done) last_done_cyc = cyc;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic m, input logic [DW-1:0] dv, input bit drop);
    int n;
    n = 0;
    in_data = d; cfg_msb_first = m; cfg_div = dv; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20000);
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    if (drop) in_valid = 1'b0;
    in_data = W'($urandom);
    cfg_div = DW'($urandom);
    cfg_msb_first = 1'($urandom);
  endtask

  // Call in the cycle after accept; k counts cycles from accept.
  task automatic capture(input int div, output logic [15:0] s, output int done_ofs,
                         output int shl, output int shr, output logic rdy_after);
    int per, last;
    per = div + 1;
    last = 1 + NB * per;
    s = '0; done_ofs = -1; shl = 0; shr = 0; rdy_after = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= last && ((k - 2) % per) == 0) s[(k - 2) / per] = ser_out;
      if (frame_done && done_ofs < 0) done_ofs = k;
      if (sr_enable && sr_mode == 2'b10) shl++;
      if (sr_enable && sr_mode == 2'b01) shr++;
      if (k == last + 1) rdy_after = in_ready;
    end
  endtask

  initial begin
    logic [15:0] s;
    int done_ofs, shl, shr, a1, n;
    logic rdy;

    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1'b1);
    chk("post_reset_ser_valid", ser_valid, 1'b0);
    chk("post_reset_sr_enable", sr_enable, 1'b0);

    send(8'h35, 1'b0, 8'd0, 1'b1);
    capture(0, s, done_ofs, shl, shr, rdy);
    chk("lsb_stream", s[7:0], 8'b00110101);
    chk("lsb_done_ofs", done_ofs, 1 + NB);
    chk("lsb_ready_after", rdy, 1'b1);
    chk("lsb_shr_pulses", shr, 8);

    send(8'h35, 1'b1, 8'd2, 1'b1);
    capture(2, s, done_ofs, shl, shr, rdy);
    chk("msb_stream", s[7:0], 8'b10101100);
    chk("msb_done_ofs", done_ofs, 1 + 3 * NB);
    chk("msb_shl_pulses", shl, 8);
    chk("msb_shr_pulses", shr, 0);

    send(8'h35, 1'b0, 8'd0, 1'b0);
    a1 = last_acc_cyc;
    send(8'hC1, 1'b0, 8'd0, 1'b1);
    chk("b2b_first_len", last_done_cyc - a1, 1 + NB);
    chk("b2b_gap", last_acc_cyc - last_done_cyc, 1);
    capture(0, s, done_ofs, shl, shr, rdy);
    chk("b2b_second_stream", s[7:0], 8'hC1);

    send(8'h35, 1'b0, 8'd2, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ser_valid", ser_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_frame_done", frame_done, 1'b0);
    send(8'hFF, 1'b0, 8'd1, 1'b1);
    capture(1, s, done_ofs, shl, shr, rdy);
    chk("ones_stream", s[7:0], 8'hFF);

`ifdef USR_CTRL_PARITY_EN
    send(8'h35, 1'b0, 8'd0, 1'b1);
    capture(0, s, done_ofs, shl, shr, rdy);
    chk("parity_35", s[8], 1'b0);
    chk("parity_35_done_ofs", done_ofs, 10);
    send(8'h07, 1'b0, 8'd1, 1'b1);
    capture(1, s, done_ofs, shl, shr, rdy);
    chk("parity_07", s[8], 1'b1);
    chk("parity_07_data", s[7:0], 8'h07);
    chk("parity_07_done_ofs", done_ofs, 19);
`endif

    send(8'hA5, 1'b1, 8'hFF, 1'b1);
    capture(255, s, done_ofs, shl, shr, rdy);
    chk("maxdiv_stream", s[7:0], 8'hA5);
    chk("maxdiv_done_ofs", done_ofs, 1 + NB * 256);

    for (int i = 0; i < 100; i++) begin
      bit drop;
      int gap;
      drop = 1'($urandom);
      gap  = $urandom_range(0, 3);
      send(W'($urandom), 1'($urandom), DW'($urandom_range(0, 7)), drop);
      if (drop) begin
        repeat (gap) begin
          @(posedge clk);
          #1 cfg_div = DW'($urandom);
        end
      end
    end
    in_valid = 1'b0;

    n = 0;
    while (q_exp.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (q_exp.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d expected cycles left, expected 0", q_exp.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
